data_memory: RTL and testbench

//  Parametrised word-organised data RAM for the RV32I core's load/store path.
//  - Byte addressing with byte, half and word access and per-byte write enables.
//  - Sign- or zero-extended reads.
//  - Programmable access latency behind a valid/ready request/response handshake.
//  - Replaces fixed-size byte arrays; sits between the load/store unit and the memory map.

---
 rtl/data_memory_pkg.sv | 19 +
 rtl/data_memory_mem_align.sv | 44 ++++
 rtl/data_memory.sv | 135 +++++++++++++
 tb/tb_data_memory.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_pkg.sv
// Shared types for the data RAM on the RV32I load/store path.
package data_memory_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

endpackage

// File: rtl/data_memory_mem_align.sv
// Lane steering: store byte enables / replication and load extension.
module mem_align
    import data_memory_pkg::*;
(
    input  logic [1:0]      size,
    input  logic [1:0]      lane,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] word,
    input  logic            uns,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata_rep,
    output logic [XLEN-1:0] rdata
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word[{lane, 3'b000} +: 8];
    assign half_sel = lane[1] ? word[31:16] : word[15:0];

    always_comb begin
        be        = 4'b0000;
        wdata_rep = wdata;
        rdata     = '0;
        case (size)
            SZ_BYTE: begin
                be        = 4'b0001 << lane;
                wdata_rep = {4{wdata[7:0]}};
                rdata     = {{24{~uns & byte_sel[7]}}, byte_sel};
            end
            SZ_HALF: begin
                be        = lane[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                rdata     = {{16{~uns & half_sel[15]}}, half_sel};
            end
            SZ_WORD: begin
                be    = 4'b1111;
                rdata = word;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// Word-organised data RAM with programmable latency and valid/ready handshake.
// Optional DMEM_MISALIGN_ERR_EN rejects misaligned half/word accesses.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err
);

    localparam int DEPTH = 2 ** (ADDR_W - 2);

    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("data_memory: LATENCY must be 1..4");
    end

    state_e            state;
    logic [1:0]        cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic              r_uns;
    logic [XLEN-1:0]   r_wdata;

    logic [ADDR_W-3:0] idx;
    logic [1:0]        lane;
    logic              err;
    logic              access;
    logic              wr_en;
    logic [3:0]        be;
    logic [XLEN-1:0]   wdata_rep;
    logic [XLEN-1:0]   rd_word;
    logic [XLEN-1:0]   ld_data;

    assign idx       = r_addr[ADDR_W-1:2];
    assign req_ready = (state == IDLE);

`ifdef DMEM_MISALIGN_ERR_EN
    logic misalign;
    assign misalign = (r_size == SZ_HALF && r_addr[0])
                   || (r_size == SZ_WORD && r_addr[1:0] != 2'b00);
    assign err = (r_size == SZ_ILL) || misalign;
`else
    assign err = (r_size == SZ_ILL);
`endif

    // Force-align: half ignores addr[0], word ignores addr[1:0]
    always_comb begin
        lane = r_addr[1:0];
        if (r_size == SZ_HALF) lane[0] = 1'b0;
        if (r_size == SZ_WORD) lane = 2'b00;
    end

    assign access = (state == WAIT) && (cnt == 2'd0);
    assign wr_en  = access && r_we && !err && !rst;

    mem_align u_align (
        .size      (r_size),
        .lane      (lane),
        .wdata     (r_wdata),
        .word      (rd_word),
        .uns       (r_uns),
        .be        (be),
        .wdata_rep (wdata_rep),
        .rdata     (ld_data)
    );

    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];
        always_ff @(posedge clk) begin
            if (wr_en && be[g]) lane_mem[idx] <= wdata_rep[8*g +: 8];
        end
        assign rd_word[8*g +: 8] = lane_mem[idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_size     <= 2'b00;
            r_uns      <= 1'b0;
            r_wdata    <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_addr  <= req_addr;
                        r_size  <= req_size;
                        r_uns   <= req_unsigned;
                        r_wdata <= req_wdata;
                        cnt     <= 2'(LATENCY - 1);
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 2'd0) begin
                        cnt <= cnt - 2'd1;
                    end else begin
                        resp_valid <= 1'b1;
                        resp_err   <= err;
                        resp_rdata <= (err || r_we) ? '0 : ld_data;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory against a byte-array reference model.
module tb_data_memory;

    localparam int AW  = 12;
    localparam int LAT = 3;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic [31:0]   resp_rdata;
    logic          resp_err;

    data_memory #(.ADDR_W(AW), .LATENCY(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t            q[$];
    byte unsigned    ref_mem [256];
    int              n_chk = 0;
    int              n_fail = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: memory as a flat byte array, little-endian.
    function automatic exp_t model(bit we, int addr, int size, bit uns,
                                   logic [31:0] wd);
        exp_t        e;
        int          n;
        int          a;
        logic [31:0] v;
        e.rdata = 0;
        e.err   = 0;
        e.acc   = 0;
        if (size == 3) begin
            e.err = 1;
            return e;
        end
        n = (size == 0) ? 1 : (size == 1) ? 2 : 4;
`ifdef DMEM_MISALIGN_ERR_EN
        if (addr % n != 0) begin
            e.err = 1;
            return e;
        end
`endif
        a = addr - (addr % n);
        if (we) begin
            for (int i = 0; i < n; i++) ref_mem[a+i] = wd[8*i +: 8];
        end else begin
            v = 0;
            for (int i = 0; i < n; i++) v = v | (32'(ref_mem[a+i]) << (8*i));
            if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
            e.rdata = v;
        end
        return e;
    endfunction

    task automatic issue(bit we, int addr, int size, bit uns,
                         logic [31:0] wd, bit push);
        int   w = 0;
        exp_t e;
        @(negedge clk);
        // While busy, wave a junk request that must be ignored
        while (!req_ready) begin
            req_valid    = 1'b1;
            req_we       = 1'($urandom);
            req_addr     = AW'($urandom);
            req_size     = 2'($urandom);
            req_unsigned = 1'($urandom);
            req_wdata    = $urandom;
            w++;
            if (w > 200) begin
                n_chk++;
                n_fail++;
                $display("FAIL issue_timeout: req_ready stuck at %b, want 1", req_ready);
                req_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = AW'(addr);
        req_size     = 2'(size);
        req_unsigned = uns;
        req_wdata    = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (push) begin
            e     = model(we, addr, size, uns, wd);
            e.acc = cyc;
            q.push_back(e);
        end
    endtask

    task automatic drain();
        int w = 0;
        while ((q.size() != 0 || !req_ready) && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (w >= 300) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: %0d responses pending, want 0", q.size());
        end
    endtask

    // Monitor: pops on first sight of each response, holds it a random time.
    initial begin : monitor
        exp_t        e;
        bit          seen;
        int          hold;
        logic [31:0] last_d;
        logic        last_e;
        seen       = 0;
        hold       = 0;
        last_d     = 0;
        last_e     = 0;
        resp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen       = 0;
                resp_ready = 1'b0;
            end else if (resp_valid) begin
                if (!seen) begin
                    seen = 1;
                    if (q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_resp: got rdata %h, want no response", resp_rdata);
                    end else begin
                        e = q.pop_front();
                        check("rdata", resp_rdata, e.rdata);
                        check("err", 32'(resp_err), 32'(e.err));
                        check("latency", 32'(cyc - e.acc), 32'(LAT));
                    end
                    last_d = resp_rdata;
                    last_e = resp_err;
                    hold   = $urandom_range(0, 5);
                end else begin
                    check("hold_rdata", resp_rdata, last_d);
                    check("hold_err", 32'(resp_err), 32'(last_e));
                end
                check("busy_ready", 32'(req_ready), 32'd0);
                if (hold == 0) begin
                    resp_ready = 1'b1;
                    seen       = 0;
                end else begin
                    hold--;
                    resp_ready = 1'b0;
                end
            end else begin
                resp_ready = 1'($urandom);
            end
        end
    end

    initial begin : stim
        int a;
        int sz;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = '0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_wdata    = '0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 256; i += 4) issue(1, i, 2, 0, $urandom, 1);

        issue(1, 'h010, 2, 0, 32'hDEAD_BEEF, 1);
        issue(0, 'h010, 2, 0, 0, 1);

        issue(1, 'h020, 2, 0, 32'h0000_0000, 1);
        issue(1, 'h021, 0, 0, 32'h0000_0080, 1);
        issue(0, 'h020, 2, 0, 0, 1);
        issue(0, 'h021, 0, 0, 0, 1);
        issue(0, 'h021, 0, 1, 0, 1);

        issue(1, 'h032, 1, 0, 32'h0000_BEEF, 1);
        issue(0, 'h032, 1, 0, 0, 1);
        issue(0, 'h030, 2, 0, 0, 1);

        issue(1, 'h041, 2, 0, 32'h1234_5678, 1);
        issue(0, 'h040, 2, 0, 0, 1);

        issue(0, 'h050, 3, 0, 0, 1);
        issue(1, 'h050, 3, 0, 32'hFFFF_FFFF, 1);
        issue(0, 'h050, 2, 0, 0, 1);

        // Reset while a store waits: store must not land
        drain();
        issue(1, 'h060, 2, 0, 32'hA5A5_A5A5, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_resp_valid", 32'(resp_valid), 32'd0);
        check("abort_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        issue(0, 'h060, 2, 0, 0, 1);

        for (int i = 0; i < 300; i++) begin
            a  = $urandom_range(0, 255);
            sz = ($urandom_range(0, 15) == 0) ? 3 : $urandom_range(0, 2);
            issue(1'($urandom), a, sz, 1'($urandom), $urandom, 1);
        end

        drain();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
